// File: rtl/bus_master_pkg.sv
// Shared types for bus_master: FSM state encoding, the queued command record and the
// command FIFO depth. Command fields are sized for the widest supported bus and narrowed at use.
package bus_master_pkg;

  localparam int CMD_FIFO_DEPTH = 4;
  localparam int CMD_ADDR_MAX   = 32;
  localparam int CMD_DATA_MAX   = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic                    wr;
    logic [CMD_ADDR_MAX-1:0] addr;
    logic [CMD_DATA_MAX-1:0] wdata;
  } cmd_t;

  function automatic cmd_t make_cmd(input logic                    wr,
                                    input logic [CMD_ADDR_MAX-1:0] addr,
                                    input logic [CMD_DATA_MAX-1:0] wdata);
    cmd_t c;
    c.wr    = wr;
    c.addr  = addr;
    c.wdata = wdata;
    return c;
  endfunction

endpackage

// File: rtl/bus_master_cmd_q.sv
// Command storage, head visible the cycle after push: 4-entry FIFO with BUS_MASTER_CMD_FIFO_EN,
// else one holding register. Caller gates push with !full and pop with !empty; push+pop may coincide.
module bus_master_cmd_q
  import bus_master_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  cmd_t push_cmd,
  input  logic pop,
  output cmd_t head,
  output logic full,
  output logic empty
);

`ifdef BUS_MASTER_CMD_FIFO_EN
  localparam int PW = $clog2(CMD_FIFO_DEPTH);

  cmd_t          mem_q [CMD_FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < CMD_FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) mem_q[wr_ptr_q] <= push_cmd;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == (PW+1)'(CMD_FIFO_DEPTH));
  assign empty = (count_q == '0);
`else
  cmd_t hold_q, hold_d;
  logic occ_q, occ_d;

  // ready is !occ, so push and pop can never land in the same cycle here
  always_comb begin
    hold_d = hold_q;
    occ_d  = occ_q;
    if (push) begin
      hold_d = push_cmd;
      occ_d  = 1'b1;
    end else if (pop) begin
      occ_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q <= '0;
      occ_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      occ_q  <= occ_d;
    end
  end

  assign head  = hold_q;
  assign full  = occ_q;
  assign empty = !occ_q;
`endif

endmodule

// File: rtl/bus_master.sv
// Bus master: queued command -> SETUP, ACCESS (write 1 cycle, read RD_WAIT+1), RESP; response held
// until rsp_ready; cmd_ready tracks storage space only. BUS_MASTER_CMD_FIFO_EN selects 4-deep storage.
module bus_master
  import bus_master_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int RD_WAIT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_wr,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              bus_sel,
  output logic              bus_wr,
  output logic [ADDR_W-1:0] bus_addr,
  inout  wire  [DATA_W-1:0] bus_data,
  output logic              busy
);

  state_e            state_q, state_d;
  logic              bus_sel_q, bus_sel_d;
  logic              bus_wr_q, bus_wr_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_wr_q, rsp_wr_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [2:0]        wait_cnt_q, wait_cnt_d;

  logic push, pop, q_full, q_empty;
  cmd_t push_cmd, head;
  logic unused_head;

  assign push     = cmd_valid && cmd_ready;
  assign push_cmd = make_cmd(cmd_wr, CMD_ADDR_MAX'(cmd_addr), CMD_DATA_MAX'(cmd_wdata));

  bus_master_cmd_q u_cmd_q (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_cmd (push_cmd),
    .pop      (pop),
    .head     (head),
    .full     (q_full),
    .empty    (q_empty)
  );

  // Upper command bits exist only to serve wider bus configurations.
  assign unused_head = ^head;

  always_comb begin
    state_d     = state_q;
    bus_sel_d   = bus_sel_q;
    bus_wr_d    = bus_wr_q;
    bus_addr_d  = bus_addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_wr_d    = rsp_wr_q;
    rsp_rdata_d = rsp_rdata_q;
    wait_cnt_d  = wait_cnt_q;
    pop         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!q_empty) pop = 1'b1;
      end
      ST_SETUP: begin
        state_d    = ST_ACCESS;
        bus_sel_d  = 1'b1;
        wait_cnt_d = '0;
      end
      ST_ACCESS: begin
        if (bus_wr_q || (wait_cnt_q == 3'(RD_WAIT))) begin
          state_d     = ST_RESP;
          bus_sel_d   = 1'b0;
          bus_wr_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_wr_d    = bus_wr_q;
          rsp_rdata_d = bus_wr_q ? '0 : bus_data;
        end else begin
          wait_cnt_d = wait_cnt_q + 3'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
          if (!q_empty) pop = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Dequeue straight into SETUP so back-to-back commands leave no idle cycle.
    if (pop) begin
      state_d    = ST_SETUP;
      bus_wr_d   = head.wr;
      bus_addr_d = head.addr[ADDR_W-1:0];
      wdata_d    = head.wdata[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      bus_sel_q   <= 1'b0;
      bus_wr_q    <= 1'b0;
      bus_addr_q  <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_wr_q    <= 1'b0;
      rsp_rdata_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      bus_sel_q   <= bus_sel_d;
      bus_wr_q    <= bus_wr_d;
      bus_addr_q  <= bus_addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_wr_q    <= rsp_wr_d;
      rsp_rdata_q <= rsp_rdata_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign bus_data  = bus_wr_q ? wdata_q : {DATA_W{1'bz}};
  assign bus_sel   = bus_sel_q;
  assign bus_wr    = bus_wr_q;
  assign bus_addr  = bus_addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_wr    = rsp_wr_q;
  assign rsp_rdata = rsp_rdata_q;
  assign cmd_ready = !q_full;
  assign busy      = (state_q != ST_IDLE) || !q_empty;

endmodule

// File: tb/tb_bus_master.sv
// Directed bench for bus_master with a small responder (status register 0x23, reset value 0x01).
// The responder parks 0xC3 on bus_data whenever the master should not be driving.
module tb_bus_master;

  logic       clk = 1'b0;
  logic       reset, cmd_valid, cmd_ready, cmd_wr;
  logic [7:0] cmd_addr, cmd_wdata;
  logic       rsp_valid, rsp_ready, rsp_wr;
  logic [7:0] rsp_rdata;
  logic       bus_sel, bus_wr, busy;
  logic [7:0] bus_addr;
  wire  [7:0] bus_data;

  logic [7:0] stat_q;
  logic [7:0] rd_val;
  int         vec = 0;
  int         err = 0;

  logic [7:0] s_addr [5] = '{8'h10, 8'h11, 8'h23, 8'h12, 8'h13};
  logic [7:0] s_exp  [5] = '{8'hB5, 8'hB4, 8'h01, 8'hB7, 8'hB6};

`ifdef BUS_MASTER_CMD_FIFO_EN
  localparam logic READY_WHILE_HELD = 1'b1;
`else
  localparam logic READY_WHILE_HELD = 1'b0;
`endif

  always #5 clk = ~clk;

  bus_master dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_wr    (cmd_wr),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_wr    (rsp_wr),
    .rsp_rdata (rsp_rdata),
    .bus_sel   (bus_sel),
    .bus_wr    (bus_wr),
    .bus_addr  (bus_addr),
    .bus_data  (bus_data),
    .busy      (busy)
  );

  assign rd_val   = (bus_addr == 8'h23) ? stat_q : (bus_addr ^ 8'hA5);
  assign bus_data = bus_wr ? 8'hzz : (bus_sel ? rd_val : 8'hC3);

  always @(posedge clk or negedge reset) begin
    if (!reset) stat_q <= 8'h01;
    else if (bus_sel && bus_wr && bus_addr == 8'h23) stat_q <= bus_data;
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vec++;
    assert (got === exp) else begin
      err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Master must leave the bus alone whenever bus_wr is low.
  always @(negedge clk) begin
    if (!bus_wr) chk("bus_release", {8'h00, bus_data}, {8'h00, (bus_sel ? rd_val : 8'hC3)});
  end

  task automatic push_cmd(input logic wr, input logic [7:0] a, input logic [7:0] d);
    int t = 0;
    while (!cmd_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("push_ready", {15'd0, cmd_ready}, 16'd1);
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Starts one cycle after acceptance (or at SETUP); returns at the first RESP cycle.
  task automatic wait_rsp(input string tag, input int exp_lat, input int exp_sel,
                          input logic exp_wr, input logic [7:0] exp_data, input logic [7:0] exp_addr);
    int n   = 1;
    int sel = 0;
    while (!rsp_valid && n < 30) begin
      if (bus_sel) begin
        sel++;
        chk({tag, "_addr"}, {8'h00, bus_addr}, {8'h00, exp_addr});
        if (bus_wr) chk({tag, "_wdata"}, {8'h00, bus_data}, {8'h00, exp_data});
      end
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 16'(n), 16'(exp_lat));
    chk({tag, "_sel_cycles"}, 16'(sel), 16'(exp_sel));
    chk({tag, "_rsp_wr"}, {15'd0, rsp_wr}, {15'd0, exp_wr});
    chk({tag, "_rdata"}, {8'h00, rsp_rdata}, {8'h00, (exp_wr ? 8'h00 : exp_data)});
  endtask

  initial begin
    int   t;
    int   sent, got, last;
    logic seen;

    reset = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0;
    cmd_addr = 8'h00; cmd_wdata = 8'h00; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_sel",   {15'd0, bus_sel},   16'd0);
    chk("rst_wr",    {15'd0, bus_wr},    16'd0);
    chk("rst_addr",  {8'h00, bus_addr},  16'd0);
    chk("rst_valid", {15'd0, rsp_valid}, 16'd0);
    chk("rst_rdata", {8'h00, rsp_rdata}, 16'd0);
    chk("rst_busy",  {15'd0, busy},      16'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {15'd0, cmd_ready}, 16'd1);

    // Read of the status register straight after reset.
    push_cmd(1'b0, 8'h23, 8'h00);
    chk("rd_busy", {15'd0, busy}, 16'd1);
    chk("rd_ready_held", {15'd0, cmd_ready}, {15'd0, READY_WHILE_HELD});
    wait_rsp("rd_rst", 5, 2, 1'b0, 8'h01, 8'h23);
    @(negedge clk);
    chk("rd_done_valid", {15'd0, rsp_valid}, 16'd0);
    chk("rd_done_busy",  {15'd0, busy},      16'd0);

    // Write 0x5A then read it back.
    push_cmd(1'b1, 8'h23, 8'h5A);
    wait_rsp("wr_5a", 4, 1, 1'b1, 8'h5A, 8'h23);
    @(negedge clk);
    push_cmd(1'b0, 8'h23, 8'h00);
    wait_rsp("rd_5a", 5, 2, 1'b0, 8'h5A, 8'h23);
    @(negedge clk);

    // Stalled response: nothing moves while rsp_ready is low, even with a command waiting.
    rsp_ready = 1'b0;
    push_cmd(1'b0, 8'h23, 8'h00);
    wait_rsp("rd_hold", 5, 2, 1'b0, 8'h5A, 8'h23);
    push_cmd(1'b1, 8'h40, 8'h77);
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", {15'd0, rsp_valid}, 16'd1);
      chk("hold_rdata", {8'h00, rsp_rdata}, 16'h005A);
      chk("hold_sel",   {15'd0, bus_sel},   16'd0);
      chk("hold_addr",  {8'h00, bus_addr},  16'h0023);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("next_valid", {15'd0, rsp_valid}, 16'd0);
    chk("next_addr",  {8'h00, bus_addr},  16'h0040);
    chk("next_wr",    {15'd0, bus_wr},    16'd1);
    chk("next_sel",   {15'd0, bus_sel},   16'd0);
    wait_rsp("wr_40", 3, 1, 1'b1, 8'h77, 8'h40);
    @(negedge clk);

    // Reset in the middle of a read ACCESS with a write still queued.
    push_cmd(1'b0, 8'h23, 8'h00);
    push_cmd(1'b1, 8'h23, 8'h99);
    t = 0;
    while (!bus_sel && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("mid_access", {14'd0, bus_sel, bus_wr}, 16'b10);
    reset = 1'b0;
    #1;
    chk("arst_sel",   {15'd0, bus_sel},   16'd0);
    chk("arst_wr",    {15'd0, bus_wr},    16'd0);
    chk("arst_addr",  {8'h00, bus_addr},  16'd0);
    chk("arst_valid", {15'd0, rsp_valid}, 16'd0);
    chk("arst_rsp_wr",{15'd0, rsp_wr},    16'd0);
    chk("arst_rdata", {8'h00, rsp_rdata}, 16'd0);
    chk("arst_busy",  {15'd0, busy},      16'd0);
    chk("arst_ready", {15'd0, cmd_ready}, 16'd1);
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid || busy || bus_sel) seen = 1'b1;
    end
    chk("arst_quiet", {15'd0, seen}, 16'd0);
    push_cmd(1'b0, 8'h23, 8'h00);
    wait_rsp("rd_after_arst", 5, 2, 1'b0, 8'h01, 8'h23);
    @(negedge clk);

    // Five back-to-back reads with rsp_ready high: order and cadence.
    sent = 0; got = 0; last = 0;
    for (int n = 0; n < 80 && got < 5; n++) begin
`ifdef BUS_MASTER_CMD_FIFO_EN
      if (n <= 6) chk("fifo_ready", {15'd0, cmd_ready}, (n == 5) ? 16'd0 : 16'd1);
`endif
      cmd_valid = (sent < 5);
      cmd_wr    = 1'b0;
      cmd_addr  = s_addr[(sent < 5) ? sent : 4];
      if (cmd_valid && cmd_ready) sent++;
      if (rsp_valid) begin
        chk("stream_rdata", {8'h00, rsp_rdata}, {8'h00, s_exp[got]});
        chk("stream_rsp_wr", {15'd0, rsp_wr}, 16'd0);
        if (got > 0) chk("stream_gap", 16'(n - last), 16'd4);
        last = n;
        got++;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("stream_count", 16'(got), 16'd5);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
